divisor_param: RTL and testbench

- Parametrised iterative restoring divider; successor to the fixed 32-bit unsigned divider.
- Adds a per-operation signed/unsigned mode, a divide-by-zero flag, a busy indication and a synchronous cancel.
- Computes one quotient bit per clock.
- Sits behind the test_if interface. The stimulus block drives start and operands; the scoreboard samples outputs on done.

---
 rtl/divisor_pkg.sv | 18 +
 rtl/divisor_paso.sv | 22 ++
 rtl/divisor_param.sv | 167 ++++++++++++++++
 tb/tb_divisor_param.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/divisor_pkg.sv
// Shared types and helpers for the parametrised restoring divider.
// Counter sizing and magnitude extraction live here so every divider width agrees.
package divisor_pkg;

    typedef enum logic [1:0] {IDLE, CALC, FIX} estado_t;

    localparam int MAX_W = 64;

    function automatic int cnt_w(input int size);
        return $clog2(size + 1);
    endfunction

    // Magnitude modulo 2^MAX_W, so the most negative value maps onto its own bit pattern.
    function automatic logic [MAX_W-1:0] abs_val(input logic signed [MAX_W-1:0] x);
        return x[MAX_W-1] ? MAX_W'(-x) : MAX_W'(x);
    endfunction

endpackage

// File: rtl/divisor_paso.sv
// One restoring-division step: shift a dividend bit into the partial remainder,
// trial-subtract the divisor magnitude, keep the difference only when it is non-negative.
module divisor_paso #(
    parameter int SIZE = 32
) (
    input  logic [SIZE-1:0] rem,
    input  logic            bit_in,
    input  logic [SIZE-1:0] den,
    output logic [SIZE-1:0] rem_nxt,
    output logic            q_bit
);

    logic [SIZE:0] shifted;

    // shifted can exceed SIZE bits, but after a successful subtract the result is below den
    always_comb begin
        shifted = {rem, bit_in};
        q_bit   = (shifted >= {1'b0, den});
        rem_nxt = q_bit ? SIZE'(shifted - {1'b0, den}) : shifted[SIZE-1:0];
    end

endmodule

// File: rtl/divisor_param.sv
// Iterative restoring divider, one quotient bit per clock, with optional signed mode,
// divide-by-zero flag, busy indication and synchronous cancel.
module divisor_param
    import divisor_pkg::*;
#(
    parameter int SIZE      = 32,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            signo,
    input  logic            cancel,
    input  logic [SIZE-1:0] num,
    input  logic [SIZE-1:0] den,
    output logic [SIZE-1:0] coc,
    output logic [SIZE-1:0] res,
    output logic            div_cero,
    output logic            busy,
    output logic            done
);

    localparam int              CNT_W   = cnt_w(SIZE);
    localparam logic [CNT_W-1:0] CNT_INI = CNT_W'(SIZE);

    estado_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SIZE-1:0]  coc_q, coc_d, res_q, res_d;
    logic             div_cero_q, div_cero_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [SIZE-1:0]  rem_q, rem_d;
    logic [SIZE-1:0]  quo_q, quo_d;
    logic [SIZE-1:0]  den_abs_q, den_abs_d;
    logic             neg_coc_q, neg_coc_d;
    logic             neg_res_q, neg_res_d;
    logic             cero_q, cero_d;

    logic                   op_signed, num_neg, den_neg;
    logic signed [SIZE-1:0] num_s, den_s;
    logic [SIZE-1:0]        num_mag, den_mag;
    logic [SIZE-1:0]        rem_nxt;
    logic                   q_bit;

    divisor_paso #(.SIZE(SIZE)) u_paso (
        .rem     (rem_q),
        .bit_in  (quo_q[SIZE-1]),
        .den     (den_abs_q),
        .rem_nxt (rem_nxt),
        .q_bit   (q_bit)
    );

    always_comb begin
        op_signed = SIGNED_EN & signo;
        num_s     = signed'(num);
        den_s     = signed'(den);
        num_neg   = op_signed & num[SIZE-1];
        den_neg   = op_signed & den[SIZE-1];
        num_mag   = num_neg ? SIZE'(abs_val(MAX_W'(num_s))) : num;
        den_mag   = den_neg ? SIZE'(abs_val(MAX_W'(den_s))) : den;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        coc_d      = coc_q;
        res_d      = res_q;
        div_cero_d = div_cero_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        rem_d      = rem_q;
        quo_d      = quo_q;
        den_abs_d  = den_abs_q;
        neg_coc_d  = neg_coc_q;
        neg_res_d  = neg_res_q;
        cero_d     = cero_q;

        if (cancel) begin
            state_d = IDLE;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        cnt_d     = CNT_INI;
                        rem_d     = '0;
                        den_abs_d = den_mag;
                        neg_coc_d = num_neg ^ den_neg;
                        neg_res_d = num_neg;
                        // On a zero divisor the raw dividend is kept so it can be returned untouched
                        if (den == '0) begin
                            quo_d   = num;
                            cero_d  = 1'b1;
                            state_d = FIX;
                        end else begin
                            quo_d   = num_mag;
                            cero_d  = 1'b0;
                            busy_d  = 1'b1;
                            state_d = CALC;
                        end
                    end
                end
                CALC: begin
                    rem_d = rem_nxt;
                    quo_d = {quo_q[SIZE-2:0], q_bit};
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = FIX;
                    end
                end
                FIX: begin
                    if (cero_q) begin
                        coc_d = '1;
                        res_d = quo_q;
                    end else begin
                        coc_d = neg_coc_q ? -quo_q : quo_q;
                        res_d = neg_res_q ? -rem_q : rem_q;
                    end
                    div_cero_d = cero_q;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    cnt_d      = '0;
                    state_d    = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            coc_q      <= '0;
            res_q      <= '0;
            div_cero_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            coc_q      <= coc_d;
            res_q      <= res_d;
            div_cero_q <= div_cero_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Datapath registers are only meaningful once an operation has been accepted
    always_ff @(posedge clk) begin
        rem_q     <= rem_d;
        quo_q     <= quo_d;
        den_abs_q <= den_abs_d;
        neg_coc_q <= neg_coc_d;
        neg_res_q <= neg_res_d;
        cero_q    <= cero_d;
    end

    assign coc      = coc_q;
    assign res      = res_q;
    assign div_cero = div_cero_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_divisor_param.sv
// Bench for divisor_param: a 32-bit and an 8-bit instance share clock and reset,
// an arithmetic reference model is compared every cycle, directed cases pin literal results.
module tb_divisor_param;

    typedef struct {
        bit          act;
        int          left;
        bit          busy;
        bit          done;
        logic [63:0] ec, er;
        bit          ez;
        logic [63:0] hc, hr;
        bit          hz;
    } mdl_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start32 = 0, signo32 = 0, cancel32 = 0;
    logic [31:0] num32 = 0, den32 = 0;
    logic [31:0] coc32, res32;
    logic        dz32, busy32, done32;

    logic        start8 = 0, signo8 = 0, cancel8 = 0;
    logic [7:0]  num8 = 0, den8 = 0;
    logic [7:0]  coc8, res8;
    logic        dz8, busy8, done8;

    int checks = 0;
    int errors = 0;

    mdl_t m32, m8;

    divisor_param #(.SIZE(32), .SIGNED_EN(1'b1)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .signo(signo32), .cancel(cancel32),
        .num(num32), .den(den32), .coc(coc32), .res(res32),
        .div_cero(dz32), .busy(busy32), .done(done32)
    );

    divisor_param #(.SIZE(8), .SIGNED_EN(1'b1)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .signo(signo8), .cancel(cancel8),
        .num(num8), .den(den8), .coc(coc8), .res(res8),
        .div_cero(dz8), .busy(busy8), .done(done8)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Reference arithmetic: truncating / and % on sign-extended values, results taken modulo 2^w
    function automatic void calc(input int w, input logic [63:0] n_in, input logic [63:0] d_in,
                                 input bit s, output logic [63:0] q, output logic [63:0] r,
                                 output bit z);
        logic [63:0] mask, n, d;
        longint sn, sd;
        mask = (64'd1 << w) - 64'd1;
        n = n_in & mask;
        d = d_in & mask;
        z = (d == 64'd0);
        if (z) begin
            q = mask;
            r = n;
        end else if (s) begin
            sn = $signed(n << (64 - w)) >>> (64 - w);
            sd = $signed(d << (64 - w)) >>> (64 - w);
            q = 64'(sn / sd) & mask;
            r = 64'(sn % sd) & mask;
        end else begin
            q = n / d;
            r = n % d;
        end
    endfunction

    function automatic mdl_t mdl_zero();
        mdl_t s;
        s.act = 0; s.left = 0; s.busy = 0; s.done = 0;
        s.ec = 0; s.er = 0; s.ez = 0; s.hc = 0; s.hr = 0; s.hz = 0;
        return s;
    endfunction

    // Transaction-level timing: a division completes w+1 edges after acceptance, a zero divisor after 1
    function automatic mdl_t step(input mdl_t s_in, input int w, input bit st, input bit cn,
                                  input bit sg, input logic [63:0] n, input logic [63:0] d);
        mdl_t s;
        s = s_in;
        s.done = 0;
        if (cn) begin
            s.act  = 0;
            s.busy = 0;
        end else if (s.act) begin
            s.left--;
            if (s.left == 0) begin
                s.act  = 0;
                s.busy = 0;
                s.done = 1;
                s.hc = s.ec; s.hr = s.er; s.hz = s.ez;
            end
        end else if (st) begin
            calc(w, n, d, sg, s.ec, s.er, s.ez);
            s.act  = 1;
            s.left = s.ez ? 1 : w + 1;
            s.busy = !s.ez;
        end
        return s;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m32 <= mdl_zero();
            m8  <= mdl_zero();
        end else begin
            m32 <= step(m32, 32, start32, cancel32, signo32, 64'(num32), 64'(den32));
            m8  <= step(m8, 8, start8, cancel8, signo8, 64'(num8), 64'(den8));
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("done32", 64'(done32), 64'(m32.done));
            chk("busy32", 64'(busy32), 64'(m32.busy));
            chk("coc32",  64'(coc32),  m32.hc);
            chk("res32",  64'(res32),  m32.hr);
            chk("dz32",   64'(dz32),   64'(m32.hz));
            chk("done8",  64'(done8),  64'(m8.done));
            chk("busy8",  64'(busy8),  64'(m8.busy));
            chk("coc8",   64'(coc8),   m8.hc);
            chk("res8",   64'(res8),   m8.hr);
            chk("dz8",    64'(dz8),    64'(m8.hz));
        end
    end

    task automatic issue32(input logic [31:0] n, input logic [31:0] d, input bit s);
        @(negedge clk);
        num32 = n; den32 = d; signo32 = s; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
    endtask

    task automatic wait32(output bit got, output int lat);
        int cyc;
        cyc = 1;
        got = 0;
        while (cyc < 120) begin
            if (done32) begin
                got = 1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        lat = cyc - 1;
    endtask

    task automatic run32(input string nm, input logic [31:0] n, input logic [31:0] d, input bit s,
                         input int exp_lat, input logic [31:0] ec, input logic [31:0] er,
                         input bit ez);
        bit got;
        int lat;
        issue32(n, d, s);
        wait32(got, lat);
        chk({nm, "_done"}, 64'(got), 64'd1);
        if (got) begin
            chk({nm, "_lat"}, 64'(lat), 64'(exp_lat));
            chk({nm, "_coc"}, 64'(coc32), 64'(ec));
            chk({nm, "_res"}, 64'(res32), 64'(er));
            chk({nm, "_dz"},  64'(dz32),  64'(ez));
        end
    endtask

    task automatic run8(input logic [7:0] n, input logic [7:0] d, input bit s);
        int cyc;
        bit got;
        @(negedge clk);
        num8 = n; den8 = d; signo8 = s; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        got = 0;
        cyc = 0;
        while (cyc < 40) begin
            if (done8) begin
                got = 1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        chk("rand8_done", 64'(got), 64'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1);
    end

    initial begin
        bit got;
        int lat;
        int dn;

        repeat (2) @(negedge clk);
        chk("rst_coc32",  64'(coc32),  64'd0);
        chk("rst_res32",  64'(res32),  64'd0);
        chk("rst_busy32", 64'(busy32), 64'd0);
        chk("rst_done32", 64'(done32), 64'd0);
        chk("rst_dz32",   64'(dz32),   64'd0);
        chk("rst_coc8",   64'(coc8),   64'd0);
        rst_n = 1'b1;

        run32("u100_7",   32'd100,        32'd7,          1'b0, 33, 32'd14,         32'd2,          1'b0);
        run32("s_m100_7", 32'hFFFFFF9C,   32'd7,          1'b1, 33, 32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0);
        run32("s_100_m7", 32'd100,        32'hFFFFFFF9,   1'b1, 33, 32'hFFFFFFF2,   32'd2,          1'b0);
        run32("divzero",  32'h12345678,   32'd0,          1'b0, 1,  32'hFFFFFFFF,   32'h12345678,   1'b1);
        run32("after_dz", 32'd100,        32'd7,          1'b0, 33, 32'd14,         32'd2,          1'b0);
        run32("overflow", 32'h80000000,   32'hFFFFFFFF,   1'b1, 33, 32'h80000000,   32'd0,          1'b0);
        run32("s_m7_2",   32'hFFFFFFF9,   32'd2,          1'b1, 33, 32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0);
        run32("u_big",    32'hFFFFFFFF,   32'h10,         1'b0, 33, 32'h0FFFFFFF,   32'hF,          1'b0);

        // Cancel mid-calculation: no completion, held results untouched
        issue32(32'd1000, 32'd3, 1'b0);
        repeat (9) @(negedge clk);
        cancel32 = 1'b1;
        @(negedge clk);
        cancel32 = 1'b0;
        chk("cancel_busy", 64'(busy32), 64'd0);
        dn = 0;
        repeat (40) begin
            @(negedge clk);
            if (done32) dn++;
        end
        chk("cancel_nodone", 64'(dn), 64'd0);
        chk("cancel_coc", 64'(coc32), 64'hFFFFFFF);
        chk("cancel_res", 64'(res32), 64'hF);

        // A start pulse while busy must not replace the running operation
        issue32(32'd1000, 32'd3, 1'b0);
        repeat (4) @(negedge clk);
        num32 = 32'd50; den32 = 32'd5; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        wait32(got, lat);
        chk("ignored_done", 64'(got), 64'd1);
        chk("ignored_coc", 64'(coc32), 64'd333);
        chk("ignored_res", 64'(res32), 64'd1);

        // Asynchronous reset in the middle of a calculation
        @(negedge clk);
        num32 = 32'd1000; den32 = 32'd3; signo32 = 1'b0; start32 = 1'b1;
        num8 = 8'd200; den8 = 8'd7; signo8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start32 = 1'b0; start8 = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_busy32", 64'(busy32), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_coc32",  64'(coc32),  64'd0);
        chk("arst_res32",  64'(res32),  64'd0);
        chk("arst_busy32", 64'(busy32), 64'd0);
        chk("arst_done32", 64'(done32), 64'd0);
        chk("arst_busy8",  64'(busy8),  64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run8(8'h80, 8'hFF, 1'b1);
        chk("ovf8_coc", 64'(coc8), 64'h80);
        chk("ovf8_res", 64'(res8), 64'h0);
        run8(8'hF6, 8'd3, 1'b1);
        chk("s8_coc", 64'(coc8), 64'hFD);
        chk("s8_res", 64'(res8), 64'hFF);

        for (int i = 0; i < 1000; i++) begin
            logic [7:0] n, d;
            n = 8'($urandom_range(0, 255));
            d = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            run8(n, d, 1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
